// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared definitions for the execute-stage branch unit and the redirect controller:
// RISC-V major opcodes, branch func3 codes and the redirect controller state.
package branch_redirect_ctrl_pkg;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_OP     = 7'b0110011,
    OP_FENCE  = 7'b0001111,
    OP_SYS    = 7'b1110011
  } opcode_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_FLUSH    = 2'd2
  } ctrl_state_e;

  // True for opcodes that can change the program counter.
  function automatic logic is_ct(input logic [6:0] op);
    logic r;
    case (op)
      OP_JAL, OP_JALR, OP_BRANCH: r = 1'b1;
      default:                    r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX = {W{1'b1}};

  // Count register: clear wins over increment, increment stops at MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= {W{1'b0}};
    end else if (clear) begin
      count <= {W{1'b0}};
    end else if (inc && (count != MAX)) begin
      count <= count + W'(1'b1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Compares resolved control transfers against the fetch prediction, drives the
// PC redirect handshake and IF/ID flush on a mispredict, and emits predictor updates.
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic [6:0]       ex_opcode,
  input  logic [1:0]       br_re,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             pred_taken,
  input  logic [XLEN-1:0]  pred_target,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush_if,
  output logic             flush_id,
  output logic             stall_ex,
  output logic             bp_upd_valid,
  output logic [XLEN-1:0]  bp_upd_pc,
  output logic [XLEN-1:0]  bp_upd_target,
  output logic             bp_upd_taken,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

  ctrl_state_e     state_r;
  ctrl_state_e     state_nx_s;
  logic [FC_W-1:0] flush_cnt_r;
  logic            is_ct_s;
  logic            accept_s;
  logic            taken_s;
  logic            mispredict_s;
  logic            handshake_s;
  logic [XLEN-1:0] target_s;
  logic [XLEN-1:0] next_pc_s;
  logic            unused_br_re_s;

  assign unused_br_re_s = br_re[1];

  // Resolve actual target/next PC and classify the incoming instruction.
  always_comb begin
    if (ex_opcode == OP_JALR) begin
      target_s = {ex_target[XLEN-1:1], 1'b0};
    end else begin
      target_s = ex_target;
    end
    taken_s = br_re[0];
    if (taken_s) begin
      next_pc_s = target_s;
    end else begin
      next_pc_s = ex_pc + XLEN'(32'd4);
    end
    mispredict_s = (pred_taken != taken_s) || (taken_s && (pred_target != target_s));
    is_ct_s      = is_ct(ex_opcode);
    accept_s     = ex_valid && ex_ready && is_ct_s;
    handshake_s  = (state_r == ST_REDIRECT) && redirect_ready;
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && mispredict_s) begin
          state_nx_s = ST_REDIRECT;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_REDIRECT: begin
        if (redirect_ready) begin
          state_nx_s = (FLUSH_CYCLES == 0) ? ST_IDLE : ST_FLUSH;
        end else begin
          state_nx_s = ST_REDIRECT;
        end
      end
      ST_FLUSH: begin
        // The counter holds the flush cycles left including this one.
        if (flush_cnt_r <= FC_W'(1'b1)) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_FLUSH;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Output decode from the state register only.
  always_comb begin
    ex_ready       = 1'b0;
    redirect_valid = 1'b0;
    flush_if       = 1'b0;
    flush_id       = 1'b0;
    stall_ex       = 1'b1;
    case (state_r)
      ST_IDLE: begin
        ex_ready = 1'b1;
        stall_ex = 1'b0;
      end
      ST_REDIRECT: redirect_valid = 1'b1;
      ST_FLUSH: begin
        flush_if = 1'b1;
        flush_id = 1'b1;
      end
      default: stall_ex = 1'b1;
    endcase
  end

  // Flush cycle counter, loaded on the redirect handshake.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      flush_cnt_r <= {FC_W{1'b0}};
    end else if (handshake_s) begin
      flush_cnt_r <= FC_W'(FLUSH_CYCLES);
    end else if ((state_r == ST_FLUSH) && (flush_cnt_r != {FC_W{1'b0}})) begin
      flush_cnt_r <= flush_cnt_r - FC_W'(1'b1);
    end else begin
      flush_cnt_r <= flush_cnt_r;
    end
  end

  // Corrected PC, frozen for the whole redirect request.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      redirect_pc <= {XLEN{1'b0}};
    end else if (accept_s && mispredict_s) begin
      redirect_pc <= next_pc_s;
    end else begin
      redirect_pc <= redirect_pc;
    end
  end

  // Predictor update pulse and payload.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bp_upd_valid  <= 1'b0;
      bp_upd_pc     <= {XLEN{1'b0}};
      bp_upd_target <= {XLEN{1'b0}};
      bp_upd_taken  <= 1'b0;
    end else if (accept_s) begin
      bp_upd_valid  <= 1'b1;
      bp_upd_pc     <= ex_pc;
      bp_upd_target <= target_s;
      bp_upd_taken  <= taken_s;
    end else begin
      bp_upd_valid  <= 1'b0;
      bp_upd_pc     <= bp_upd_pc;
      bp_upd_target <= bp_upd_target;
      bp_upd_taken  <= bp_upd_taken;
    end
  end

  sat_counter #(.W(CNT_W)) u_br_cnt (
    .clk   (CLK),
    .rst_n (RST_N),
    .inc   (accept_s),
    .clear (1'b0),
    .count (br_cnt)
  );

  sat_counter #(.W(CNT_W)) u_mispred_cnt (
    .clk   (CLK),
    .rst_n (RST_N),
    .inc   (accept_s && mispredict_s),
    .clear (1'b0),
    .count (mispred_cnt)
  );

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: one instance with a 2-cycle flush and
// 4-bit counters, one with no flush cycles, both checked against a behavioural model.
module tb_branch_redirect_ctrl;

  localparam logic [6:0] OPC_JAL  = 7'h6F;
  localparam logic [6:0] OPC_JALR = 7'h67;
  localparam logic [6:0] OPC_BR   = 7'h63;
  localparam logic [6:0] OPC_ALU  = 7'h33;

  logic        clk, rst_n;
  logic [6:0]  ex_opcode;
  logic [1:0]  br_re;
  logic [31:0] ex_pc, ex_target, pred_target;
  logic        pred_taken;
  logic        ex_valid_a, redirect_ready_a, ex_valid_z, redirect_ready_z;

  logic        ex_ready_a, redirect_valid_a, flush_if_a, flush_id_a, stall_ex_a;
  logic        bp_upd_valid_a, bp_upd_taken_a;
  logic [31:0] redirect_pc_a, bp_upd_pc_a, bp_upd_target_a;
  logic [3:0]  br_cnt_a, mispred_cnt_a;

  logic        ex_ready_z, redirect_valid_z, flush_if_z, flush_id_z, stall_ex_z;
  logic        bp_upd_valid_z, bp_upd_taken_z;
  logic [31:0] redirect_pc_z, bp_upd_pc_z, bp_upd_target_z;
  logic [15:0] br_cnt_z, mispred_cnt_z;

  int n_tests = 0;
  int n_fail  = 0;

  branch_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(4)) dut (
    .CLK(clk), .RST_N(rst_n), .ex_valid(ex_valid_a), .ex_ready(ex_ready_a),
    .ex_opcode(ex_opcode), .br_re(br_re), .ex_pc(ex_pc), .ex_target(ex_target),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .redirect_valid(redirect_valid_a), .redirect_ready(redirect_ready_a),
    .redirect_pc(redirect_pc_a), .flush_if(flush_if_a), .flush_id(flush_id_a),
    .stall_ex(stall_ex_a), .bp_upd_valid(bp_upd_valid_a), .bp_upd_pc(bp_upd_pc_a),
    .bp_upd_target(bp_upd_target_a), .bp_upd_taken(bp_upd_taken_a),
    .br_cnt(br_cnt_a), .mispred_cnt(mispred_cnt_a)
  );

  branch_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(0), .CNT_W(16)) dut_z (
    .CLK(clk), .RST_N(rst_n), .ex_valid(ex_valid_z), .ex_ready(ex_ready_z),
    .ex_opcode(ex_opcode), .br_re(br_re), .ex_pc(ex_pc), .ex_target(ex_target),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .redirect_valid(redirect_valid_z), .redirect_ready(redirect_ready_z),
    .redirect_pc(redirect_pc_z), .flush_if(flush_if_z), .flush_id(flush_id_z),
    .stall_ex(stall_ex_z), .bp_upd_valid(bp_upd_valid_z), .bp_upd_pc(bp_upd_pc_z),
    .bp_upd_target(bp_upd_target_z), .bp_upd_taken(bp_upd_taken_z),
    .br_cnt(br_cnt_z), .mispred_cnt(mispred_cnt_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model, one slot per instance: pending redirect, flush cycles left.
  bit          m_pend[2];
  int          m_fl[2];
  logic [31:0] m_rpc[2];
  bit          m_uv[2];
  logic [31:0] m_upc[2], m_utgt[2];
  bit          m_ut[2];
  int          m_br[2], m_mis[2];
  int          m_fc[2]  = '{2, 0};
  int          m_max[2] = '{15, 65535};

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = 0; m_fl[i] = 0; m_rpc[i] = 32'h0; m_uv[i] = 0;
      m_upc[i] = 32'h0; m_utgt[i] = 32'h0; m_ut[i] = 0; m_br[i] = 0; m_mis[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input logic v, input logic rdy);
    bit busy, acc, tk, mis;
    logic [31:0] tgt, nxt;
    busy = m_pend[i] || (m_fl[i] > 0);
    acc  = v && !busy && (ex_opcode == OPC_JAL || ex_opcode == OPC_JALR || ex_opcode == OPC_BR);
    m_uv[i] = acc;
    if (acc) begin
      tgt = (ex_opcode == OPC_JALR) ? (ex_target & ~32'h1) : ex_target;
      tk  = br_re[0];
      nxt = tk ? tgt : ex_pc + 32'd4;
      mis = (pred_taken != tk) || (tk && pred_target != tgt);
      m_upc[i] = ex_pc; m_utgt[i] = tgt; m_ut[i] = tk;
      if (m_br[i] < m_max[i]) m_br[i]++;
      if (mis && m_mis[i] < m_max[i]) m_mis[i]++;
      if (mis) begin
        m_pend[i] = 1;
        m_rpc[i]  = nxt;
      end
    end else if (m_pend[i] && rdy) begin
      m_pend[i] = 0;
      m_fl[i]   = m_fc[i];
    end else if (m_fl[i] > 0) begin
      m_fl[i]--;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input int i, input logic rdy, input logic rv, input logic [31:0] rpc,
                     input logic fi, input logic fid, input logic st, input logic uv,
                     input logic [31:0] upc, input logic [31:0] utg, input logic ut,
                     input logic [31:0] bc, input logic [31:0] mc);
    string p;
    bit busy;
    p = (i == 0) ? "a." : "z.";
    busy = m_pend[i] || (m_fl[i] > 0);
    chk({p, "ex_ready"}, {31'b0, rdy}, {31'b0, !busy});
    chk({p, "redirect_valid"}, {31'b0, rv}, {31'b0, m_pend[i]});
    chk({p, "redirect_pc"}, rpc, m_rpc[i]);
    chk({p, "flush_if"}, {31'b0, fi}, {31'b0, m_fl[i] > 0});
    chk({p, "flush_id"}, {31'b0, fid}, {31'b0, m_fl[i] > 0});
    chk({p, "stall_ex"}, {31'b0, st}, {31'b0, busy});
    chk({p, "bp_upd_valid"}, {31'b0, uv}, {31'b0, m_uv[i]});
    chk({p, "bp_upd_pc"}, upc, m_upc[i]);
    chk({p, "bp_upd_target"}, utg, m_utgt[i]);
    chk({p, "bp_upd_taken"}, {31'b0, ut}, {31'b0, m_ut[i]});
    chk({p, "br_cnt"}, bc, m_br[i]);
    chk({p, "mispred_cnt"}, mc, m_mis[i]);
  endtask

  // Inputs only change just after a falling edge, so at the falling edge they still
  // equal what the preceding rising edge sampled.
  always @(negedge clk) begin
    if (rst_n) begin
      model_step(0, ex_valid_a, redirect_ready_a);
      model_step(1, ex_valid_z, redirect_ready_z);
      cmp(0, ex_ready_a, redirect_valid_a, redirect_pc_a, flush_if_a, flush_id_a, stall_ex_a,
          bp_upd_valid_a, bp_upd_pc_a, bp_upd_target_a, bp_upd_taken_a,
          {28'b0, br_cnt_a}, {28'b0, mispred_cnt_a});
      cmp(1, ex_ready_z, redirect_valid_z, redirect_pc_z, flush_if_z, flush_id_z, stall_ex_z,
          bp_upd_valid_z, bp_upd_pc_z, bp_upd_target_z, bp_upd_taken_z,
          {16'b0, br_cnt_z}, {16'b0, mispred_cnt_z});
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_ct(input logic [6:0] op, input logic [1:0] br, input logic [31:0] pc,
                        input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
    ex_opcode = op; br_re = br; ex_pc = pc; ex_target = tgt;
    pred_taken = pt; pred_target = ptgt;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    ex_valid_a = 1'b0; ex_valid_z = 1'b0;
    redirect_ready_a = 1'b1; redirect_ready_z = 1'b1;
    set_ct(OPC_ALU, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
    model_reset();
    repeat (3) tick();
    chk("rst.redirect_valid", {31'b0, redirect_valid_a}, 32'h0);
    chk("rst.br_cnt", {28'b0, br_cnt_a}, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("rst.ex_ready", {31'b0, ex_ready_a}, 32'h1);

    // JAL predicted correctly.
    set_ct(OPC_JAL, 2'b01, 32'h100, 32'h200, 1'b1, 32'h200);
    ex_valid_a = 1'b1;
    tick();
    ex_valid_a = 1'b0;
    chk("jal.bp_upd_valid", {31'b0, bp_upd_valid_a}, 32'h1);
    chk("jal.bp_upd_taken", {31'b0, bp_upd_taken_a}, 32'h1);
    chk("jal.bp_upd_target", bp_upd_target_a, 32'h200);
    chk("jal.redirect_valid", {31'b0, redirect_valid_a}, 32'h0);
    chk("jal.br_cnt", {28'b0, br_cnt_a}, 32'h1);
    chk("jal.mispred_cnt", {28'b0, mispred_cnt_a}, 32'h0);
    tick();
    chk("jal.pulse_end", {31'b0, bp_upd_valid_a}, 32'h0);

    // BEQ not taken but predicted taken: redirect to 0x44, two flush cycles.
    set_ct(OPC_BR, 2'b00, 32'h40, 32'h80, 1'b1, 32'h80);
    ex_valid_a = 1'b1;
    tick();
    ex_valid_a = 1'b0;
    chk("beq.redirect_valid", {31'b0, redirect_valid_a}, 32'h1);
    chk("beq.redirect_pc", redirect_pc_a, 32'h44);
    chk("beq.stall1", {31'b0, stall_ex_a}, 32'h1);
    chk("beq.mispred_cnt", {28'b0, mispred_cnt_a}, 32'h1);
    tick();
    chk("beq.flush1", {31'b0, flush_if_a}, 32'h1);
    chk("beq.rv_drop", {31'b0, redirect_valid_a}, 32'h0);
    tick();
    chk("beq.flush2", {31'b0, flush_id_a}, 32'h1);
    chk("beq.stall3", {31'b0, stall_ex_a}, 32'h1);
    tick();
    chk("beq.flush_end", {31'b0, flush_if_a}, 32'h0);
    chk("beq.ex_ready", {31'b0, ex_ready_a}, 32'h1);

    // JALR target bit0 cleared, matches prediction.
    set_ct(OPC_JALR, 2'b01, 32'h1000, 32'h301, 1'b1, 32'h300);
    ex_valid_a = 1'b1;
    tick();
    ex_valid_a = 1'b0;
    chk("jalr.bp_upd_target", bp_upd_target_a, 32'h300);
    chk("jalr.redirect_valid", {31'b0, redirect_valid_a}, 32'h0);
    chk("jalr.mispred_cnt", {28'b0, mispred_cnt_a}, 32'h1);
    tick();

    // Taken branch predicted not-taken, fetch stalls the redirect for 5 cycles.
    redirect_ready_a = 1'b0;
    set_ct(OPC_BR, 2'b01, 32'h500, 32'h600, 1'b0, 32'h0);
    ex_valid_a = 1'b1;
    tick();
    chk("hold.rv1", {31'b0, redirect_valid_a}, 32'h1);
    chk("hold.rpc1", redirect_pc_a, 32'h600);
    set_ct(OPC_JAL, 2'b01, 32'h700, 32'h800, 1'b1, 32'h800);
    for (int k = 2; k <= 5; k++) begin
      tick();
      chk("hold.rv", {31'b0, redirect_valid_a}, 32'h1);
      chk("hold.rpc", redirect_pc_a, 32'h600);
      chk("hold.ex_ready", {31'b0, ex_ready_a}, 32'h0);
      chk("hold.no_upd", {31'b0, bp_upd_valid_a}, 32'h0);
    end
    ex_valid_a = 1'b0;
    redirect_ready_a = 1'b1;
    tick();
    chk("hold.rv_done", {31'b0, redirect_valid_a}, 32'h0);
    chk("hold.flush", {31'b0, flush_if_a}, 32'h1);
    chk("hold.br_cnt", {28'b0, br_cnt_a}, 32'h4);
    chk("hold.mispred_cnt", {28'b0, mispred_cnt_a}, 32'h2);
    tick();
    tick();
    chk("hold.ex_ready_back", {31'b0, ex_ready_a}, 32'h1);

    // Non control-transfer opcode is ignored.
    set_ct(OPC_ALU, 2'b01, 32'h900, 32'h0, 1'b0, 32'h0);
    ex_valid_a = 1'b1;
    tick();
    ex_valid_a = 1'b0;
    chk("alu.no_upd", {31'b0, bp_upd_valid_a}, 32'h0);
    chk("alu.br_cnt", {28'b0, br_cnt_a}, 32'h4);

    // Back-to-back correct transfers.
    set_ct(OPC_JAL, 2'b01, 32'h900, 32'h904, 1'b1, 32'h904);
    ex_valid_a = 1'b1;
    tick();
    chk("b2b.upd1", {31'b0, bp_upd_valid_a}, 32'h1);
    chk("b2b.pc1", bp_upd_pc_a, 32'h900);
    set_ct(OPC_JAL, 2'b01, 32'hA00, 32'hA80, 1'b1, 32'hA80);
    tick();
    ex_valid_a = 1'b0;
    chk("b2b.upd2", {31'b0, bp_upd_valid_a}, 32'h1);
    chk("b2b.pc2", bp_upd_pc_a, 32'hA00);
    chk("b2b.br_cnt", {28'b0, br_cnt_a}, 32'h6);
    tick();

    // 20 more correct transfers saturate the 4-bit branch counter.
    ex_valid_a = 1'b1;
    for (int k = 0; k < 20; k++) begin
      set_ct(OPC_JAL, 2'b01, 32'h2000 + 32'(k) * 32'd4, 32'h3000, 1'b1, 32'h3000);
      tick();
    end
    ex_valid_a = 1'b0;
    tick();
    chk("sat.br_cnt", {28'b0, br_cnt_a}, 32'hF);
    chk("sat.mispred_cnt", {28'b0, mispred_cnt_a}, 32'h2);

    // Reset asserted in the middle of a flush.
    set_ct(OPC_BR, 2'b00, 32'h40, 32'h80, 1'b1, 32'h80);
    ex_valid_a = 1'b1;
    tick();
    ex_valid_a = 1'b0;
    tick();
    chk("mrst.in_flush", {31'b0, flush_if_a}, 32'h1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mrst.flush_if", {31'b0, flush_if_a}, 32'h0);
    chk("mrst.flush_id", {31'b0, flush_id_a}, 32'h0);
    chk("mrst.stall_ex", {31'b0, stall_ex_a}, 32'h0);
    chk("mrst.ex_ready", {31'b0, ex_ready_a}, 32'h1);
    chk("mrst.redirect_pc", redirect_pc_a, 32'h0);
    chk("mrst.bp_upd_pc", bp_upd_pc_a, 32'h0);
    chk("mrst.br_cnt", {28'b0, br_cnt_a}, 32'h0);
    chk("mrst.mispred_cnt", {28'b0, mispred_cnt_a}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mrst.after", {31'b0, ex_ready_a}, 32'h1);

    // Zero-flush instance: redirect cycle then straight back to ready.
    set_ct(OPC_BR, 2'b00, 32'h40, 32'h80, 1'b1, 32'h80);
    ex_valid_z = 1'b1;
    tick();
    ex_valid_z = 1'b0;
    chk("zf.redirect_valid", {31'b0, redirect_valid_z}, 32'h1);
    chk("zf.redirect_pc", redirect_pc_z, 32'h44);
    tick();
    chk("zf.ex_ready", {31'b0, ex_ready_z}, 32'h1);
    chk("zf.flush_if", {31'b0, flush_if_z}, 32'h0);
    chk("zf.mispred_cnt", {16'b0, mispred_cnt_z}, 32'h1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
